xpt2046_touch_reader: RTL

SPI master and touch qualifier for the XPT2046 resistive touch controller on the LCD shield. It sits directly upstream of the colour-choice and face-entry screens.
- Polls raw 12-bit X and Y conversions while the pen is down.
- Debounces press and release.
- Presents x_touch, y_touch and the touch_input level that the screen modules consume.

---
 rtl/xpt2046_touch_reader.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/xpt2046_touch_reader.sv
`timescale 1ns / 1ps
// XPT2046 touch reader: debounces PENIRQ, reads raw 12-bit X/Y over mode-0 SPI while the pen
// is down, and presents the last accepted coordinate pair plus a debounced touch level.
module xpt2046_touch_reader #(
    parameter int         CLK_DIV         = 1,
    parameter int         DEBOUNCE_CYCLES = 1000,
    parameter int         SAMPLE_INTERVAL = 5000,
    parameter logic [7:0] CMD_X           = 8'hD0,
    parameter logic [7:0] CMD_Y           = 8'h90
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pen_irq_n,
    input  logic        spi_miso,
    output logic        spi_sclk,
    output logic        spi_mosi,
    output logic        spi_cs_n,
    output logic [11:0] x_touch,
    output logic [11:0] y_touch,
    output logic        touch_input,
    output logic        sample_valid
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SIW = $clog2(SAMPLE_INTERVAL + 1);

    localparam logic [7:0]     DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [8:0]     GAP_LAST = 9'(2 * CLK_DIV - 1);
    localparam logic [DBW-1:0] DEB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SIW-1:0] INT_LAST = SIW'(SAMPLE_INTERVAL - 1);
    localparam logic [4:0]     LAST_BIT = 5'd23;

    typedef enum logic [2:0] {
        IDLE,
        CONV_X,
        CS_GAP,
        CONV_Y,
        UPDATE,
        HOLD
    } state_t;

    state_t state;
    state_t next_state;

    logic [DBW-1:0] deb_cnt;
    logic [DBW-1:0] rel_cnt;
    logic [SIW-1:0] int_cnt;
    logic [7:0]     div_cnt;
    logic           half;
    logic [4:0]     bit_cnt;
    logic [8:0]     gap_cnt;
    logic [11:0]    shift;
    logic [11:0]    x_raw;
    logic [7:0]     cmd_byte;

    logic in_conv;
    logic phase_end;
    logic sclk_rise;
    logic conv_done;
    logic gap_done;
    logic pressed;
    logic released;
    logic interval_done;

    assign in_conv       = (state == CONV_X) || (state == CONV_Y);
    assign phase_end     = in_conv && (div_cnt == DIV_LAST);
    assign sclk_rise     = phase_end && !half;
    assign conv_done     = phase_end && half && (bit_cnt == LAST_BIT);
    assign gap_done      = (state == CS_GAP) && (gap_cnt == GAP_LAST);
    assign pressed       = !pen_irq_n && (deb_cnt == DEB_LAST);
    assign released      = pen_irq_n && (rel_cnt == DEB_LAST);
    assign interval_done = (int_cnt == INT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (pressed) begin
                    next_state = CONV_X;
                end
            end
            CONV_X: begin
                if (conv_done) begin
                    next_state = CS_GAP;
                end
            end
            CS_GAP: begin
                if (gap_done) begin
                    next_state = CONV_Y;
                end
            end
            CONV_Y: begin
                if (conv_done) begin
                    next_state = UPDATE;
                end
            end
            UPDATE: begin
                next_state = HOLD;
            end
            HOLD: begin
                // A completed release wins over an interval that expires in the same cycle.
                if (released) begin
                    next_state = IDLE;
                end else if (interval_done && !pen_irq_n) begin
                    next_state = CONV_X;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        cmd_byte = (state == CONV_X) ? CMD_X : CMD_Y;
        if (in_conv) begin
            spi_cs_n = 1'b0;
            spi_sclk = half;
            if (bit_cnt < 5'd8) begin
                spi_mosi = cmd_byte[3'd7 - bit_cnt[2:0]];
            end
        end
    end

    // Press/release debounce and the inter-sample interval; all idle at zero outside their state.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_cnt <= '0;
            rel_cnt <= '0;
            int_cnt <= '0;
        end else begin
            if (state == IDLE && !pen_irq_n && !pressed) begin
                deb_cnt <= deb_cnt + 1'b1;
            end else begin
                deb_cnt <= '0;
            end

            if (state == HOLD && pen_irq_n && !released) begin
                rel_cnt <= rel_cnt + 1'b1;
            end else begin
                rel_cnt <= '0;
            end

            if (state == HOLD) begin
                if (!interval_done) begin
                    int_cnt <= int_cnt + 1'b1;
                end
            end else begin
                int_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !in_conv) begin
            div_cnt <= '0;
            half    <= 1'b0;
            bit_cnt <= '0;
        end else if (phase_end) begin
            div_cnt <= '0;
            half    <= !half;
            if (half) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || state != CS_GAP) begin
            gap_cnt <= '0;
        end else begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end

    // Only the 12 data slots (bits 9..20) are kept; BUSY and the trailing zeros never matter.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift <= '0;
            x_raw <= '0;
        end else begin
            if (sclk_rise && bit_cnt >= 5'd9 && bit_cnt <= 5'd20) begin
                shift <= {shift[10:0], spi_miso};
            end
            if (state == CONV_X && conv_done) begin
                x_raw <= shift;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_touch      <= '0;
            y_touch      <= '0;
            touch_input  <= 1'b0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (state == UPDATE && !pen_irq_n) begin
                x_touch      <= x_raw;
                y_touch      <= shift;
                touch_input  <= 1'b1;
                sample_valid <= 1'b1;
            end else if ((state == HOLD && released) || state == IDLE) begin
                touch_input <= 1'b0;
            end
        end
    end

endmodule
